ibuffer_rd_burst_ctrl: RTL and testbench
========================================

Name: ibuffer_rd_burst_ctrl

Overview:
- Sequencer that drives port a (read side) of the single-SRAM input buffer.
- Accepts one burst descriptor at a time: base address, beat count and address stride.
- Issues the read beats with last_a on the final one and limits the number of outstanding reads.
- Counts returned beats and reports completion or abort to the iDMA/iNoC control logic.

Parameters:
- ADDR_W, 15: buffer word address width.
- DEPTH, 24576: valid buffer words (24 banks x 1024). Addresses at or above DEPTH are never issued.
- LEN_W, 12: width of cmd_len (beats minus 1).
- MAX_OUTST, 4: maximum number of issued but unreturned read beats.
- CNT_W, 3: outstanding-counter width. Must hold MAX_OUTST.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  descriptor accepted when cmd_valid && cmd_ready.
- cmd_base  in  ADDR_W  first word address. Must be < DEPTH.
- cmd_len  in  LEN_W  number of beats minus 1.
- cmd_stride  in  ADDR_W  address increment per beat. Must be < DEPTH.
- abort  in  1  level; stop issuing and drain.
- cen_a  out  1  read request to buffer port a.
- wen_a  out  1  constant 0.
- addr_a  out  ADDR_W  read address.
- last_a  out  1  marks the final beat of the burst.
- ready_a  in  1  port a accept.
- rvalid_a  in  1  monitored read data valid.
- rlast_a  in  1  monitored read last.
- rready_a  in  1  monitored consumer ready; owned by the downstream consumer.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- done_aborted  out  1  qualifies done: the burst was cut by abort.
- outst  out  CNT_W  current outstanding read count.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state IDLE, cen_a=0, last_a=0, addr_a=0, done=0, done_aborted=0, outst=0, busy=0. cmd_ready=1 once reset is released (it equals state==IDLE).
- Accept/issue: a request is accepted when cen_a && ready_a. outst increments on accept and decrements on rvalid_a && rready_a. When both happen in the same cycle, outst is unchanged.

State IDLE:
- cmd_ready=1.
- On a cmd handshake, latch base, len and stride; clear the beat counter; go to ISSUE.
- cen_a is asserted in the cycle after the handshake (latency 1).

State ISSUE:
- cen_a = (outst < MAX_OUTST) && !abort_seen.
- addr_a is the current address. It holds stable while cen_a && !ready_a.
- last_a = cen_a && (beat_cnt == len).
- On accept, next address = addr + stride; if the sum is >= DEPTH, subtract DEPTH (wrap inside the buffer). Compute the sum at ADDR_W+1 bits. beat_cnt increments.
- When the last_a beat is accepted, go to DRAIN.
- cmd_len=0 gives a single beat, with last_a on the first beat.

abort:
- abort is sampled each cycle in ISSUE. Once set, abort_seen stays set until IDLE.
- From the next cycle, cen_a=0 (it may drop while unaccepted; the buffer holds no commitment). Go to DRAIN with aborted=1.
- abort in IDLE or DRAIN has no effect.

State DRAIN:
- Normal completion: wait for the rvalid_a && rready_a && rlast_a handshake with outst reaching 0.
- Aborted completion: wait for outst==0. rlast_a never arrives, so it is not checked.
- Then done=1 for one cycle, done_aborted=aborted, return to IDLE.
- done is registered: it rises the cycle after the final response handshake, or the cycle after outst reaches 0.

Errors and reset:
- rlast_a handshake while outst would go to 0 but the state is not DRAIN: protocol error. It is not masked; an assertion flags it.
- Reset mid-burst returns everything to reset values immediately. No responses are tracked afterwards. The buffer pipeline must also be reset by the same rst_n.

Decomposition:
- Shared ibuf package: state encoding (IDLE, ISSUE, DRAIN), IBUF_DEPTH=24576, IBUF_ADDR_W=15.
- Sub-module ibuf_outst_cnt: saturating-checked up/down counter with inc, dec, full (==MAX_OUTST) and zero outputs.
- Address wrap and FSM stay in the top.

Test Plan:
1. Basic burst, consumer always ready, ready_a always 1: base=0x0100, len=3, stride=1 -> addr_a 0x100..0x103 on 4 consecutive cycles; last_a only on 0x103; done one cycle after the 4th rlast handshake; done_aborted=0.
2. Wrap at DEPTH: base=24574, len=3, stride=1 -> addresses 24574, 24575, 0, 1. Repeat with stride=8, base=24570 -> 24570, 2, 10, 18.
3. Outstanding limit: rready_a=0 for 20 cycles, len=9 -> exactly 4 accepts, then cen_a=0 and outst=4. Release rready_a -> issue resumes; outst never exceeds 4; all 10 beats return; done pulses once.
4. ready_a held 0 for 3 cycles with cen_a=1 -> addr_a and last_a stable across the stall; the beat is counted once.
5. abort after 2 accepts of len=7 -> cen_a=0 the next cycle; done arrives once the 2 outstanding beats return, with done_aborted=1. The next cmd is accepted normally.
6. Reset mid-burst (rst_n low with outst=3) -> cen_a, busy and outst read 0 asynchronously; cmd_ready=1 after release.

Source files
------------

// File: rtl/ibuf_pkg.sv
// ----------------------------------------------------------------------------
// ibuf_pkg
// Definitions shared by the input-buffer read-side sequencer and its helpers:
//   - IBUF_DEPTH  : number of valid buffer words (24 banks x 1024 words)
//   - IBUF_ADDR_W : buffer word address width
//   - ibuf_state_t: read burst sequencer states
// ----------------------------------------------------------------------------
package ibuf_pkg;

    localparam int IBUF_DEPTH  = 24576;
    localparam int IBUF_ADDR_W = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } ibuf_state_t;

endpackage

// File: rtl/ibuf_outst_cnt.sv
// ----------------------------------------------------------------------------
// ibuf_outst_cnt
// Up/down counter of issued-but-unreturned read beats.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : one beat issued this cycle
//   dec        : one beat returned this cycle
//   count      : current outstanding count
//   full       : count == MAX_OUTST
//   zero       : count == 0
// Simultaneous inc and dec leave the count unchanged. The count saturates at
// 0 and MAX_OUTST; reaching either limit with a one-sided request is a caller
// bug and is flagged by assertions.
// ----------------------------------------------------------------------------
module ibuf_outst_cnt #(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign full  = (cnt_q == CNT_W'(MAX_OUTST));
    assign zero  = (cnt_q == '0);
    assign count = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !full) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && !zero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inc && !dec && full));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec && !inc && zero));

endmodule

// File: rtl/ibuffer_rd_burst_ctrl.sv
// ----------------------------------------------------------------------------
// ibuffer_rd_burst_ctrl
// Drives read port a of the single-SRAM input buffer with one burst at a time.
// A descriptor (base, len = beats-1, stride) is accepted in IDLE; beats are
// issued in ISSUE with addresses wrapping inside DEPTH, and at most MAX_OUTST
// beats may be outstanding. DRAIN waits for the returns, then pulses done.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       : descriptor handshake
//   cmd_base/cmd_len/cmd_stride: descriptor fields
//   abort                     : level, stops issuing while in ISSUE
//   cen_a/wen_a/addr_a/last_a : read request to buffer port a
//   ready_a                   : port a accepts the request
//   rvalid_a/rlast_a/rready_a : monitored read response handshake
//   busy                      : sequencer not idle
//   done/done_aborted         : completion pulse and its abort qualifier
//   outst                     : outstanding read count
// ----------------------------------------------------------------------------
module ibuffer_rd_burst_ctrl
    import ibuf_pkg::*;
#(
    parameter int ADDR_W    = IBUF_ADDR_W,
    parameter int DEPTH     = IBUF_DEPTH,
    parameter int LEN_W     = 12,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_stride,
    input  logic              abort,
    output logic              cen_a,
    output logic              wen_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic              last_a,
    input  logic              ready_a,
    input  logic              rvalid_a,
    input  logic              rlast_a,
    input  logic              rready_a,
    output logic              busy,
    output logic              done,
    output logic              done_aborted,
    output logic [CNT_W-1:0]  outst
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    ibuf_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              abort_seen_q, abort_seen_d;
    logic              done_q, done_d;
    logic              done_aborted_q, done_aborted_d;

    logic              accept;
    logic              rsp_hs;
    logic              outst_full;
    logic              outst_zero;
    logic              outst_one;
    logic [CNT_W-1:0]  outst_cnt;
    logic [ADDR_W:0]   addr_sum;
    logic [ADDR_W-1:0] addr_inc;

    assign accept = cen_a && ready_a;
    assign rsp_hs = rvalid_a && rready_a;

    ibuf_outst_cnt #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) u_outst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .dec   (rsp_hs),
        .count (outst_cnt),
        .full  (outst_full),
        .zero  (outst_zero)
    );

    assign outst_one = (outst_cnt == CNT_W'(1));

    // Both operands are below DEPTH, so one conditional subtract keeps the
    // next address inside the buffer. The extra bit holds the carry.
    always_comb begin
        addr_sum = {1'b0, addr_q} + {1'b0, stride_q};
        if (addr_sum >= DEPTH_EXT) begin
            addr_inc = ADDR_W'(addr_sum - DEPTH_EXT);
        end else begin
            addr_inc = ADDR_W'(addr_sum);
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        stride_d       = stride_q;
        len_d          = len_q;
        beat_cnt_d     = beat_cnt_q;
        abort_seen_d   = abort_seen_q;
        done_d         = 1'b0;
        done_aborted_d = 1'b0;
        cmd_ready      = 1'b0;
        cen_a          = 1'b0;
        last_a         = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready    = 1'b1;
                abort_seen_d = 1'b0;
                if (cmd_valid) begin
                    addr_d     = cmd_base;
                    stride_d   = cmd_stride;
                    len_d      = cmd_len;
                    beat_cnt_d = '0;
                    state_d    = ISSUE;
                end
            end

            ISSUE: begin
                // An unaccepted request may be withdrawn by abort; the buffer
                // holds no commitment until ready_a.
                cen_a  = !outst_full && !abort_seen_q;
                last_a = cen_a && (beat_cnt_q == len_q);
                if (accept) begin
                    addr_d     = addr_inc;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_a) begin
                        state_d = DRAIN;
                    end
                end
                if (abort) begin
                    abort_seen_d = 1'b1;
                    state_d      = DRAIN;
                end
            end

            DRAIN: begin
                // No beats are issued here, so the final return is the one
                // seen while exactly one beat remains outstanding.
                if (abort_seen_q) begin
                    if (outst_zero || (outst_one && rsp_hs)) begin
                        done_d         = 1'b1;
                        done_aborted_d = 1'b1;
                        abort_seen_d   = 1'b0;
                        state_d        = IDLE;
                    end
                end else if (rsp_hs && rlast_a && outst_one) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            stride_q       <= '0;
            len_q          <= '0;
            beat_cnt_q     <= '0;
            abort_seen_q   <= 1'b0;
            done_q         <= 1'b0;
            done_aborted_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            stride_q       <= stride_d;
            len_q          <= len_d;
            beat_cnt_q     <= beat_cnt_d;
            abort_seen_q   <= abort_seen_d;
            done_q         <= done_d;
            done_aborted_q <= done_aborted_d;
        end
    end

    assign wen_a        = 1'b0;
    assign addr_a       = addr_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign done_aborted = done_aborted_q;
    assign outst        = outst_cnt;

    // A last response that empties the counter outside DRAIN means the
    // consumer and this sequencer disagree about burst boundaries.
    a_rlast_outside_drain: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_hs && rlast_a && outst_one && !accept && (state_q != DRAIN)));

endmodule

// File: tb/tb_ibuffer_rd_burst_ctrl.sv
module tb_ibuffer_rd_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [14:0] cmd_base, cmd_stride;
    logic [11:0] cmd_len;
    logic        abort;
    logic        cen_a, wen_a, last_a, ready_a;
    logic [14:0] addr_a;
    logic        rvalid_a, rlast_a, rready_a;
    logic        busy, done, done_aborted;
    logic [2:0]  outst;

    always #5 clk = ~clk;

    ibuffer_rd_burst_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_base     (cmd_base),
        .cmd_len      (cmd_len),
        .cmd_stride   (cmd_stride),
        .abort        (abort),
        .cen_a        (cen_a),
        .wen_a        (wen_a),
        .addr_a       (addr_a),
        .last_a       (last_a),
        .ready_a      (ready_a),
        .rvalid_a     (rvalid_a),
        .rlast_a      (rlast_a),
        .rready_a     (rready_a),
        .busy         (busy),
        .done         (done),
        .done_aborted (done_aborted),
        .outst        (outst)
    );

    typedef struct {
        logic [14:0] addr;
        logic        last;
    } iss_t;

    iss_t exp_iss_q[$];
    logic exp_done_q[$];
    bit   rsp_q[$];
    int   acc_cyc_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_total = 0;
    int done_cnt = 0;
    int last_rsp_cyc = -10;
    bit acc_now = 1'b0;
    bit acc_last = 1'b0;
    bit rsp_now = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted request and every done pulse pops
    // its expected entry.
    always @(negedge clk) begin : mon
        iss_t e;
        if (rst_n) begin
            acc_now  = cen_a && ready_a;
            acc_last = last_a;
            rsp_now  = rvalid_a && rready_a;
            if (acc_now) begin
                acc_total++;
                acc_cyc_q.push_back(cyc);
                if (exp_iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: addr 0x%0h last %0b, no beat required", addr_a, last_a);
                end else begin
                    e = exp_iss_q.pop_front();
                    chk("issue_addr", 32'(addr_a), 32'(e.addr));
                    chk("issue_last", 32'(last_a), 32'(e.last));
                end
            end
            if (rsp_now) last_rsp_cyc = cyc;
            chk("outst_le_max", 32'(outst <= 3'd4), 32'd1);
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done_aborted %0b, no completion required", done_aborted);
                end else begin
                    chk("done_aborted", 32'(done_aborted), 32'(exp_done_q.pop_front()));
                    chk("done_latency", 32'(cyc), 32'(last_rsp_cyc + 1));
                end
            end
        end else begin
            acc_now = 1'b0;
            rsp_now = 1'b0;
        end
    end

    // Buffer model: each accepted read returns one cycle later, in order.
    initial begin
        rvalid_a = 1'b0;
        rlast_a  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rsp_q.delete();
            end else begin
                if (rsp_now && rsp_q.size() > 0) void'(rsp_q.pop_front());
                if (acc_now) rsp_q.push_back(acc_last);
            end
            rvalid_a = (rsp_q.size() > 0);
            rlast_a  = (rsp_q.size() > 0) ? rsp_q[0] : 1'b0;
        end
    end

    task automatic push_iss(input logic [14:0] a, input logic l);
        iss_t e;
        e.addr = a;
        e.last = l;
        exp_iss_q.push_back(e);
    endtask

    task automatic send_cmd(input logic [14:0] base, input logic [11:0] len,
                            input logic [14:0] stride, output int hs_cyc);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b1;
        cmd_base   = base;
        cmd_len    = len;
        cmd_stride = stride;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_handshake_timeout: cmd_ready 0, required 1");
        end
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: no done within 300 cycles, required one", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int a0;
        int n;
        cmd_valid  = 1'b0;
        cmd_base   = '0;
        cmd_len    = '0;
        cmd_stride = '0;
        abort      = 1'b0;
        ready_a    = 1'b1;
        rready_a   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cen_a", 32'(cen_a), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_cen_a_rel", 32'(cen_a), 0);
        chk("rst_last_a", 32'(last_a), 0);
        chk("rst_addr_a", 32'(addr_a), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_aborted", 32'(done_aborted), 0);
        chk("rst_outst", 32'(outst), 0);
        chk("rst_wen_a", 32'(wen_a), 0);

        // 1: basic burst
        acc_cyc_q.delete();
        push_iss(15'h100, 0); push_iss(15'h101, 0); push_iss(15'h102, 0); push_iss(15'h103, 1);
        exp_done_q.push_back(1'b0);
        send_cmd(15'h100, 12'd3, 15'd1, hs);
        wait_done("t1");
        chk("t1_beats", 32'(acc_cyc_q.size()), 4);
        if (acc_cyc_q.size() == 4) begin
            chk("t1_first_latency", 32'(acc_cyc_q[0]), 32'(hs + 1));
            chk("t1_consecutive", 32'(acc_cyc_q[3] - acc_cyc_q[0]), 3);
        end
        $display("t1 basic burst: 4 beats from 0x100 issued");

        // 2: address wrap at DEPTH
        push_iss(15'd24574, 0); push_iss(15'd24575, 0); push_iss(15'd0, 0); push_iss(15'd1, 1);
        exp_done_q.push_back(1'b0);
        send_cmd(15'd24574, 12'd3, 15'd1, hs);
        wait_done("t2a");
        $display("t2a wrap stride 1 from 24574");
        push_iss(15'd24570, 0); push_iss(15'd2, 0); push_iss(15'd10, 0); push_iss(15'd18, 1);
        exp_done_q.push_back(1'b0);
        send_cmd(15'd24570, 12'd3, 15'd8, hs);
        wait_done("t2b");
        $display("t2b wrap stride 8 from 24570");

        // 3: outstanding limit
        @(posedge clk);
        #1;
        rready_a = 1'b0;
        for (int i = 0; i < 10; i++) push_iss(15'h400 + 15'(i), (i == 9));
        exp_done_q.push_back(1'b0);
        a0 = acc_total;
        send_cmd(15'h400, 12'd9, 15'd1, hs);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_accepts_held", 32'(acc_total - a0), 4);
        @(negedge clk);
        chk("t3_cen_a_full", 32'(cen_a), 0);
        chk("t3_outst_full", 32'(outst), 4);
        @(posedge clk);
        #1;
        rready_a = 1'b1;
        wait_done("t3");
        chk("t3_accepts_total", 32'(acc_total - a0), 10);
        $display("t3 outstanding limit: 10 beats through a 4-deep window");

        // 4: port stall, single beat burst
        @(posedge clk);
        #1;
        ready_a = 1'b0;
        push_iss(15'h200, 1);
        exp_done_q.push_back(1'b0);
        a0 = acc_total;
        send_cmd(15'h200, 12'd0, 15'd5, hs);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_cen_a", 32'(cen_a), 1);
            chk("t4_stall_addr", 32'(addr_a), 32'h200);
            chk("t4_stall_last", 32'(last_a), 1);
        end
        @(posedge clk);
        #1;
        ready_a = 1'b1;
        wait_done("t4");
        chk("t4_accepts", 32'(acc_total - a0), 1);
        $display("t4 stall: beat 0x200 held 3 cycles, counted once");

        // 5: abort after two accepts
        @(posedge clk);
        #1;
        rready_a = 1'b0;
        push_iss(15'h300, 0); push_iss(15'h302, 0);
        exp_done_q.push_back(1'b1);
        a0 = acc_total;
        send_cmd(15'h300, 12'd7, 15'd2, hs);
        n = 0;
        @(negedge clk);
        while (!(outst == 3'd1 && cen_a && ready_a) && n < 50) begin
            n++;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        chk("t5_cen_after_abort", 32'(cen_a), 0);
        chk("t5_outst", 32'(outst), 2);
        chk("t5_busy", 32'(busy), 1);
        repeat (2) @(posedge clk);
        #1;
        rready_a = 1'b1;
        wait_done("t5");
        abort = 1'b0;
        chk("t5_accepts", 32'(acc_total - a0), 2);
        $display("t5 abort: 2 beats issued, aborted completion");
        push_iss(15'h010, 0); push_iss(15'h013, 1);
        exp_done_q.push_back(1'b0);
        send_cmd(15'h010, 12'd1, 15'd3, hs);
        wait_done("t5b");
        $display("t5b command after abort completed");

        // 6: reset mid-burst
        @(posedge clk);
        #1;
        rready_a = 1'b0;
        for (int i = 0; i < 8; i++) push_iss(15'(i), (i == 7));
        send_cmd(15'd0, 12'd7, 15'd1, hs);
        n = 0;
        @(negedge clk);
        while (outst != 3'd3 && n < 50) begin
            n++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cen_a", 32'(cen_a), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_outst", 32'(outst), 0);
        exp_iss_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rready_a = 1'b1;
        @(negedge clk);
        chk("t6_cmd_ready", 32'(cmd_ready), 1);
        chk("t6_outst_after", 32'(outst), 0);
        push_iss(15'd24575, 1);
        exp_done_q.push_back(1'b0);
        send_cmd(15'd24575, 12'd0, 15'd0, hs);
        wait_done("t6");
        $display("t6 reset mid-burst, recovery burst at 24575");

        repeat (3) @(posedge clk);
        #1;
        chk("end_issue_queue_empty", 32'(exp_iss_q.size()), 0);
        chk("end_done_queue_empty", 32'(exp_done_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
